// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states and access owner IDs.
package dmem_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select: eligibility, starvation override, CPU priority.
module dmem_arb_pick #(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              cpu_req,
  input  logic              dbg_req,
  input  logic              cpu_ack,
  input  logic              dbg_ack,
  input  logic              cpu_busy,
  input  logic              dbg_busy,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              win,
  output logic              win_dbg,
  output logic              dbg_elig
);

  logic cpu_elig;
  logic starve;

  always_comb begin
    cpu_elig = cpu_req & ~cpu_busy & ~cpu_ack;
    dbg_elig = dbg_req & ~dbg_busy & ~dbg_ack;
    starve   = dbg_elig & (wait_cnt == WAIT_W'(MAX_WAIT));
    win      = cpu_elig | dbg_elig;
    win_dbg  = starve | (~cpu_elig & dbg_elig);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one registered access per cycle, CPU priority,
// bounded debug starvation, one-cycle ack with registered read data.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [15:0] dbg_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  state_t                    state, state_nxt;
  owner_t                    gnt;
  logic [WAIT_W-1:0]         wait_cnt;
  logic                      we_p1;
  logic signed [ADDR_W-1:0]  addr_p1;
  logic signed [DATA_W-1:0]  wdata_p1;
  logic                      win, win_dbg, dbg_elig;
  logic                      cpu_busy, dbg_busy;

  assign cpu_busy  = (state == ST_ACC) && (gnt == OWN_CPU);
  assign dbg_busy  = (state == ST_ACC) && (gnt == OWN_DBG);
  assign cpu_stall = cpu_req & ~cpu_ack;

  dmem_arb_pick #(
    .MAX_WAIT(MAX_WAIT),
    .WAIT_W  (WAIT_W)
  ) u_pick (
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .cpu_ack (cpu_ack),
    .dbg_ack (dbg_ack),
    .cpu_busy(cpu_busy),
    .dbg_busy(dbg_busy),
    .wait_cnt(wait_cnt),
    .win     (win),
    .win_dbg (win_dbg),
    .dbg_elig(dbg_elig)
  );

  always_comb begin
    state_nxt = win ? ST_ACC : ST_IDLE;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ST_ACC) begin
      mem_re    = ~we_p1;
      mem_we    = we_p1;
      mem_addr  = addr_p1;
      mem_wdata = wdata_p1;
    end
  end

  // p0 -> p1: winner's request captured onto the memory port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      gnt      <= OWN_CPU;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (win) gnt <= win_dbg ? OWN_DBG : OWN_CPU;
      if (!dbg_req || (win && win_dbg)) wait_cnt <= '0;
      else if (dbg_elig && (wait_cnt != WAIT_W'(MAX_WAIT))) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (win) begin
      we_p1    <= win_dbg ? dbg_we    : cpu_we;
      addr_p1  <= win_dbg ? dbg_addr  : cpu_addr;
      wdata_p1 <= win_dbg ? dbg_wdata : cpu_wdata;
    end
  end

  // p1 -> p2: access completes, owner gets ack and (for reads) data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      cpu_ack <= cpu_busy;
      dbg_ack <= dbg_busy;
      if (cpu_busy && !we_p1) cpu_rdata <= mem_rdata;
      if (dbg_busy && !we_p1) dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory model, vector table for CPU accesses,
// hand sequences for contention, starvation, reset mid-access and held requests.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_ack, cpu_stall, dbg_ack;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        mem_re, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  dmem_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req  (dbg_req),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_ack  (dbg_ack),
    .dbg_rdata(dbg_rdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Byte-addressed memory, little-endian 16-bit words, combinational read
  logic [7:0]  mem [0:65535];
  logic [15:0] addr_hi;
  assign addr_hi   = mem_addr + 16'd1;
  assign mem_rdata = {mem[addr_hi], mem[mem_addr]};
  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata[7:0];
      mem[addr_hi]  <= mem_wdata[15:8];
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cpu_q[$];
  logic [15:0] dbg_q[$];
  logic [15:0] cpu_last = 16'h0000;
  logic [15:0] dbg_last = 16'h0000;
  logic        cpu_stream = 1'b0;
  logic [15:0] stream_val = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops the expected rdata pushed when the request was driven
  always @(negedge clock) begin
    if (reset) begin
      if (cpu_ack) begin
        if (cpu_stream) check("cpu_rdata_stream", cpu_rdata, stream_val);
        else if (cpu_q.size() == 0) check("cpu_unexpected_ack", 1, 0);
        else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (dbg_ack) begin
        if (dbg_q.size() == 0) check("dbg_unexpected_ack", 1, 0);
        else check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end
    end
  end

  task automatic cpu_txn(input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rd);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (!we) cpu_last = rd;
    cpu_q.push_back(cpu_last);
    @(negedge clock);
    check("acc_mem_we", mem_we, we);
    check("acc_mem_re", mem_re, !we);
    check("acc_mem_addr", mem_addr, addr);
    check("acc_mem_wdata", mem_wdata, wdata);
    check("acc_stall", cpu_stall, 1);
    check("acc_no_ack", cpu_ack, 0);
    @(negedge clock);
    check("ack_latency", cpu_ack, 1);
    check("ack_stall", cpu_stall, 0);
    check("ack_mem_idle", mem_we | mem_re, 0);
    cpu_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dbg_lat, last_ack, max_gap, n_cpu_acks;
    bit got;

    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 16'h0100, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 16'h0100, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 16'h0011, 16'hA55A, 16'h0000};
    vecs[5] = '{1'b0, 16'h0010, 16'h0000, 16'h5AEF};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h99;
    mem[1] = 8'hAB;

    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    repeat (2) @(negedge clock);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_mem_ctl", {mem_re, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_stall", cpu_stall, 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) cpu_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rd);

    // Simultaneous requests: CPU first, debug the following cycle
    @(negedge clock);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0000;
    cpu_last = 16'h5AEF; cpu_q.push_back(cpu_last);
    dbg_last = 16'hAB99; dbg_q.push_back(dbg_last);
    @(negedge clock);
    check("both_acc_cpu", {cpu_ack, dbg_ack, mem_re, mem_addr}, {3'b001, 16'h0010});
    @(negedge clock);
    check("both_cpu_ack", {cpu_ack, dbg_ack}, 2'b10);
    check("both_dbg_acc", {mem_re, mem_addr}, {1'b1, 16'h0000});
    cpu_req = 0;
    @(negedge clock);
    check("both_dbg_ack", {cpu_ack, dbg_ack}, 2'b01);
    dbg_req = 0;
    @(negedge clock);

    // CPU requesting continuously while debug writes
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    stream_val = 16'h5AEF; cpu_stream = 1'b1;
    dbg_lat = -1; last_ack = 0; max_gap = 0; n_cpu_acks = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      if (cpu_ack) begin
        n_cpu_acks++;
        if (n_cpu_acks > 1 && (i - last_ack) > max_gap) max_gap = i - last_ack;
        last_ack = i;
      end
      if (dbg_ack && dbg_lat < 0) begin
        dbg_lat = i - 1;
        dbg_req = 0;
      end
      if (i == 1) begin
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0200; dbg_wdata = 16'h7777;
        dbg_q.push_back(dbg_last);
      end
    end
    dbg_req = 0;
    check("starve_dbg_acked", dbg_lat >= 0, 1);
    check("starve_dbg_bound", dbg_lat <= 5, 1);
    check("starve_cpu_acks", n_cpu_acks >= 4, 1);
    check("starve_cpu_gap", max_gap <= 4, 1);
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clock);
      if (cpu_ack) got = 1;
    end
    check("stream_end_ack", got, 1);
    cpu_req = 0;
    @(negedge clock);
    cpu_stream = 1'b0;
    cpu_txn(1'b0, 16'h0200, 16'h0000, 16'h7777);

    // Reset in the middle of a CPU write
    @(negedge clock);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'hDEAD;
    @(negedge clock);
    check("rstacc_mem_we", mem_we, 1);
    reset = 1'b0;
    #1;
    check("rstacc_mem_drop", {mem_we, mem_re, mem_addr, mem_wdata}, 0);
    check("rstacc_rdata", cpu_rdata, 0);
    cpu_req = 0;
    @(negedge clock);
    check("rstacc_no_ack", cpu_ack, 0);
    reset = 1'b1;
    cpu_last = 16'h0000; dbg_last = 16'h0000;
    repeat (2) @(negedge clock);
    check("rstacc_idle", {cpu_ack, mem_we, mem_re}, 0);
    cpu_txn(1'b0, 16'h0020, 16'h0000, 16'h0000);

    // Request held through the ack cycle: second access only after a non-ack cycle
    @(negedge clock);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
    cpu_last = 16'h1234; cpu_q.push_back(cpu_last); cpu_q.push_back(cpu_last);
    @(negedge clock);
    check("hold_acc1", mem_re, 1);
    @(negedge clock);
    check("hold_ack1", cpu_ack, 1);
    @(negedge clock);
    check("hold_gap", {mem_re, cpu_ack, cpu_stall}, 3'b001);
    @(negedge clock);
    check("hold_acc2", mem_re, 1);
    @(negedge clock);
    check("hold_ack2", cpu_ack, 1);
    cpu_req = 0;
    repeat (3) @(negedge clock);
    check("final_cpu_q", cpu_q.size(), 0);
    check("final_dbg_q", dbg_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
